wb_arbiter: RTL and testbench

Writeback arbiter that sits in front of the register file's single write port and merges results from two producers: the single-cycle ALU path and the variable-latency load path. Load returns are buffered in a small FIFO, and one write per cycle is driven onto `rd_addr`/`rd_data`/`write_en` from a registered output stage. The arbiter also gives the issue stage pending-write hazard flags and, optionally, same-cycle forwarding of the in-flight write.

---
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter merging the ALU path and a buffered load-return path.
// Macro WB_BYPASS_EN enables same-cycle forwarding of the presented write.
// Ports: clk/rst_n; alu_* and ld_* producer handshakes;
// rd_addr/rd_data/write_en registered writes; rN_addr in; rN_busy and rN_fwd_* out.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            write_en,
  input  logic [AW-1:0]   r1_addr,
  input  logic [AW-1:0]   r2_addr,
  output logic            r1_busy,
  output logic            r2_busy,
  output logic            r1_fwd_valid,
  output logic            r2_fwd_valid,
  output logic [XLEN-1:0] r1_fwd_data,
  output logic [XLEN-1:0] r2_fwd_data
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW:0] ptr_t;

  logic [AW-1:0]   fifo_rd_q  [DEPTH];
  logic [XLEN-1:0] fifo_dat_q [DEPTH];
  ptr_t            wptr_q, wptr_d;
  ptr_t            rptr_q, rptr_d;
  ptr_t            count;
  logic [1:0]      starve_q, starve_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            we_q, we_d;

  logic            empty, full, push, fifo_gnt, alu_acc, gnt;
  logic [AW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_dat;
  logic [PW-1:0]   off;

  // Extra pointer bit separates full from empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW] != rptr_q[PW]) &&
                 (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign count = wptr_q - rptr_q;

  assign ld_ready = !full;
  assign push     = ld_valid && !full;

  // Load head wins unless the ALU has already waited three cycles.
  assign fifo_gnt  = !empty && (starve_q != 2'd3);
  assign alu_ready = empty || (starve_q == 2'd3);
  assign alu_acc   = alu_valid && alu_ready;
  assign gnt       = fifo_gnt || alu_acc;

  always_comb begin
    wptr_d   = wptr_q + ptr_t'(push);
    rptr_d   = rptr_q + ptr_t'(fifo_gnt);
    starve_d = starve_q;
    if (alu_acc || !alu_valid) begin
      starve_d = 2'd0;
    end else if (fifo_gnt) begin
      starve_d = starve_q + 2'd1;
    end
    gnt_rd  = alu_rd;
    gnt_dat = alu_data;
    if (fifo_gnt) begin
      gnt_rd  = fifo_rd_q[rptr_q[PW-1:0]];
      gnt_dat = fifo_dat_q[rptr_q[PW-1:0]];
    end
    we_d      = gnt && (gnt_rd != '0);
    rd_addr_d = gnt ? gnt_rd  : rd_addr_q;
    rd_data_d = gnt ? gnt_dat : rd_data_q;
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    r1_busy = 1'b0;
    r2_busy = 1'b0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rptr_q[PW-1:0];
      if ({1'b0, off} < count) begin
        if (fifo_rd_q[i] == r1_addr) r1_busy = 1'b1;
        if (fifo_rd_q[i] == r2_addr) r2_busy = 1'b1;
      end
    end
    if (r1_addr == '0) r1_busy = 1'b0;
    if (r2_addr == '0) r2_busy = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      starve_q  <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      we_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]  <= '0;
        fifo_dat_q[i] <= '0;
      end
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      starve_q  <= starve_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      we_q      <= we_d;
      if (push) begin
        fifo_rd_q[wptr_q[PW-1:0]]  <= ld_rd;
        fifo_dat_q[wptr_q[PW-1:0]] <= ld_data;
      end
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign write_en = we_q;

`ifdef WB_BYPASS_EN
  assign r1_fwd_valid = we_q && (r1_addr == rd_addr_q) && (r1_addr != '0);
  assign r2_fwd_valid = we_q && (r2_addr == rd_addr_q) && (r2_addr != '0);
  assign r1_fwd_data  = rd_data_q;
  assign r2_fwd_data  = rd_data_q;
`else
  assign r1_fwd_valid = 1'b0;
  assign r2_fwd_valid = 1'b0;
  assign r1_fwd_data  = '0;
  assign r2_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed bench for wb_arbiter.
// A queue-level model of the writeback rules supplies every expected value.
module tb_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid, ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            write_en;
  logic [AW-1:0]   r1_addr, r2_addr;
  logic            r1_busy, r2_busy;
  logic            r1_fwd_valid, r2_fwd_valid;
  logic [XLEN-1:0] r1_fwd_data, r2_fwd_data;

  wb_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rd(ld_rd), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .write_en(write_en),
    .r1_addr(r1_addr), .r2_addr(r2_addr),
    .r1_busy(r1_busy), .r2_busy(r2_busy),
    .r1_fwd_valid(r1_fwd_valid), .r2_fwd_valid(r2_fwd_valid),
    .r1_fwd_data(r1_fwd_data), .r2_fwd_data(r2_fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  int              mstarve = 0;
  logic            e_we = 1'b0;
  logic [AW-1:0]   e_addr = '0;
  logic [XLEN-1:0] e_data = '0;
  int              n_chk = 0;
  int              n_fail = 0;
  int              ld_seq = 0;

  function automatic logic m_alu_ready();
    return (mq.size() == 0) || (mstarve == 3);
  endfunction

  function automatic logic m_ld_ready();
    return mq.size() < DEPTH;
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_fwd_v(input logic [AW-1:0] a);
`ifdef WB_BYPASS_EN
    return e_we && (a == e_addr) && (a != '0);
`else
    return (a != a);
`endif
  endfunction

  function automatic logic [XLEN-1:0] m_fwd_d();
`ifdef WB_BYPASS_EN
    return e_data;
`else
    return '0;
`endif
  endfunction

  // One clock of the writeback rules applied to the held inputs.
  task automatic model_step();
    bit   was_full, fg, acc;
    ent_t e;
    was_full = (mq.size() == DEPTH);
    fg  = (mq.size() != 0) && (mstarve < 3);
    acc = alu_valid && m_alu_ready();
    if (fg) begin
      e = mq.pop_front();
      e_we = (e.rd != '0); e_addr = e.rd; e_data = e.data;
    end else if (acc) begin
      e_we = (alu_rd != '0); e_addr = alu_rd; e_data = alu_data;
    end else begin
      e_we = 1'b0;
    end
    if (acc || !alu_valid) mstarve = 0;
    else if (fg) mstarve++;
    if (ld_valid && !was_full) begin
      e.rd = ld_rd; e.data = ld_data;
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    r1_addr = '0; r2_addr = '0;
  endtask

  task automatic set_load();
    ld_rd   = AW'((ld_seq % 31) + 1);
    ld_data = XLEN'(32'h10 * (ld_seq + 1));
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (write_en !== 1'b0 || rd_addr !== '0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_out: we=%b addr=%0d data=%h, want 0/0/0", write_en, rd_addr, rd_data);
    end
    n_chk++;
    if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdy: ld=%b alu=%b, want 1/1", ld_ready, alu_ready);
    end
    n_chk++;
    if (r1_busy !== 1'b0 || r2_busy !== 1'b0 || r1_fwd_valid !== 1'b0 || r2_fwd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: b=%b%b f=%b%b, want 0", r1_busy, r2_busy, r1_fwd_valid, r2_fwd_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    n_chk++;
    if (alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_ready: got %b want 1", alu_ready);
    end
    tick();
    idle_inputs();
    #1;
    n_chk++;
    if (write_en !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL alu_write: we=%b addr=%0d data=%h want 1/5/deadbeef", write_en, rd_addr, rd_data);
    end
    tick();
  endtask

  task automatic test_x0_busy();
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hAA;
    tick();
    ld_rd = 5'd7; ld_data = 32'h77; r1_addr = 5'd0;
    #1;
    n_chk++;
    if (r1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_busy: got %b want 0", r1_busy);
    end
    tick();
    ld_valid = 1'b0; r1_addr = 5'd7;
    #1;
    n_chk++;
    if (write_en !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_we: got %b want 0", write_en);
    end
    n_chk++;
    if (r1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy7: got %b want 1", r1_busy);
    end
    r1_addr = 5'd0;
    #1;
    n_chk++;
    if (r1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy0: got %b want 0", r1_busy);
    end
    tick();
    r1_addr = 5'd7;
    #1;
    n_chk++;
    if (write_en !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h77 || r1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ld7_write: we=%b addr=%0d data=%h busy=%b want 1/7/77/0",
               write_en, rd_addr, rd_data, r1_busy);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_fwd();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1234;
    tick();
    idle_inputs();
    r2_addr = 5'd9; r1_addr = 5'd10;
    #1;
    n_chk++;
`ifdef WB_BYPASS_EN
    if (r2_fwd_valid !== 1'b1 || r2_fwd_data !== 32'h1234) begin
      n_fail++;
      $display("FAIL fwd_hit: v=%b d=%h want 1/1234", r2_fwd_valid, r2_fwd_data);
    end
`else
    if (r2_fwd_valid !== 1'b0 || r2_fwd_data !== '0) begin
      n_fail++;
      $display("FAIL fwd_off: v=%b d=%h want 0/0", r2_fwd_valid, r2_fwd_data);
    end
`endif
    n_chk++;
    if (r1_fwd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_miss: got %b want 0", r1_fwd_valid);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_fill();
    int full_seen;
    full_seen = 0;
    alu_valid = 1'b1; ld_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      alu_rd = 5'd20; alu_data = 32'hA000_0000 + i;
      set_load();
      #1;
      n_chk++;
      if (ld_ready !== m_ld_ready() || alu_ready !== m_alu_ready()) begin
        n_fail++;
        $display("FAIL fill_rdy[%0d]: ld=%b alu=%b want %b/%b", i, ld_ready, alu_ready,
                 m_ld_ready(), m_alu_ready());
      end
      n_chk++;
      if (write_en !== e_we || rd_addr !== e_addr || rd_data !== e_data) begin
        n_fail++;
        $display("FAIL fill_wr[%0d]: %b/%0d/%h want %b/%0d/%h", i, write_en, rd_addr, rd_data,
                 e_we, e_addr, e_data);
      end
      if (ld_ready === 1'b0) full_seen++;
      if (m_ld_ready()) ld_seq++;
      tick();
    end
    n_chk++;
    if (full_seen == 0) begin
      n_fail++;
      $display("FAIL fill_full: ld_ready low cycles=%0d want >0", full_seen);
    end
  endtask

  task automatic test_starvation();
    int last;
    last = -1;
    alu_valid = 1'b1; ld_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      alu_rd = 5'd21; alu_data = 32'hB000_0000 + i;
      set_load();
      #1;
      n_chk++;
      if (alu_ready !== m_alu_ready()) begin
        n_fail++;
        $display("FAIL starve_rdy[%0d]: got %b want %b", i, alu_ready, m_alu_ready());
      end
      if (alu_ready === 1'b1) begin
        if (last >= 0) begin
          n_chk++;
          if (i - last != 4) begin
            n_fail++;
            $display("FAIL starve_gap: got %0d want 4", i - last);
          end
        end
        last = i;
      end
      n_chk++;
      if (write_en !== e_we || rd_addr !== e_addr || rd_data !== e_data) begin
        n_fail++;
        $display("FAIL starve_wr[%0d]: %b/%0d/%h want %b/%0d/%h", i, write_en, rd_addr, rd_data,
                 e_we, e_addr, e_data);
      end
      if (m_ld_ready()) ld_seq++;
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    alu_valid = 1'b0; ld_valid = 1'b0;
    for (int i = 0; i < 10 && mq.size() > 2; i++) tick();
    r1_addr = mq.size() > 0 ? mq[0].rd : 5'd1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h44;
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (write_en !== 1'b0 || rd_addr !== '0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_out: we=%b addr=%0d data=%h want 0", write_en, rd_addr, rd_data);
    end
    n_chk++;
    if (ld_ready !== 1'b1 || alu_ready !== 1'b1 || r1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_rdy: ld=%b alu=%b busy=%b want 1/1/0", ld_ready, alu_ready, r1_busy);
    end
    mq.delete(); mstarve = 0;
    e_we = 1'b0; e_addr = '0; e_data = '0;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (write_en !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_release[%0d]: we=%b want 0", i, write_en);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_rd    = AW'($urandom_range(0, 31));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 3) != 0);
      ld_rd     = AW'($urandom_range(0, 31));
      ld_data   = $urandom;
      r1_addr   = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[mq.size()-1].rd
                                                                : AW'($urandom_range(0, 31));
      r2_addr   = $urandom_range(0, 1) == 1 ? e_addr : AW'($urandom_range(0, 31));
      #1;
      n_chk++;
      if (alu_ready !== m_alu_ready() || ld_ready !== m_ld_ready()) begin
        n_fail++;
        $display("FAIL rnd_rdy[%0d]: alu=%b ld=%b want %b/%b", i, alu_ready, ld_ready,
                 m_alu_ready(), m_ld_ready());
      end
      n_chk++;
      if (write_en !== e_we || rd_addr !== e_addr || rd_data !== e_data) begin
        n_fail++;
        $display("FAIL rnd_wr[%0d]: %b/%0d/%h want %b/%0d/%h", i, write_en, rd_addr, rd_data,
                 e_we, e_addr, e_data);
      end
      n_chk++;
      if (r1_busy !== m_busy(r1_addr) || r2_busy !== m_busy(r2_addr)) begin
        n_fail++;
        $display("FAIL rnd_busy[%0d]: %b%b want %b%b", i, r1_busy, r2_busy,
                 m_busy(r1_addr), m_busy(r2_addr));
      end
      n_chk++;
      if (r1_fwd_valid !== m_fwd_v(r1_addr) || r2_fwd_valid !== m_fwd_v(r2_addr) ||
          r1_fwd_data !== m_fwd_d() || r2_fwd_data !== m_fwd_d()) begin
        n_fail++;
        $display("FAIL rnd_fwd[%0d]: v=%b%b d=%h want v=%b%b d=%h", i, r1_fwd_valid, r2_fwd_valid,
                 r1_fwd_data, m_fwd_v(r1_addr), m_fwd_v(r2_addr), m_fwd_d());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_x0_busy();
    test_fwd();
    test_fill();
    test_starvation();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
